// File: rtl/display_mux_if.sv
// display_mux_if
//  Connects the calculator operand registers to the multiplexed 7-segment driver.
//  master: the operand source (drives snapshot inputs, observes the display pins).
//  slave : display_mux (samples snapshot inputs, drives the display pins).
//  Signals:
//   operand    DIGIT_NUM*4  BCD digits, nibble 0 = least significant
//   sign       1            1 = negative
//   brightness 4            0 = dark ... 15 = max (15/16 duty)
//   blank_lz   1            1 = blank leading zeros
//   load       1            request a new snapshot
//   seg        7            {g,f,e,d,c,b,a}, active-high
//   dig_sel    DIGIT_NUM    one-hot digit enable, active-high
//   sign_ovf   1            negative value with no free digit for the minus glyph
//   frame_tick 1            one-clock pulse when the scan wraps to digit 0
interface display_mux_if #(
  parameter int unsigned DIGIT_NUM = 8
);
  logic [DIGIT_NUM*4-1:0] operand;
  logic                   sign;
  logic [3:0]             brightness;
  logic                   blank_lz;
  logic                   load;
  logic [6:0]             seg;
  logic [DIGIT_NUM-1:0]   dig_sel;
  logic                   sign_ovf;
  logic                   frame_tick;

  modport master (
    output operand, sign, brightness, blank_lz, load,
    input  seg, dig_sel, sign_ovf, frame_tick
  );

  modport slave (
    input  operand, sign, brightness, blank_lz, load,
    output seg, dig_sel, sign_ovf, frame_tick
  );
endinterface

// File: rtl/display_mux.sv
// display_mux
//  Multiplexed 7-segment display driver. Snapshots operand/sign/brightness/blank_lz on
//  load into a pending buffer that is applied only when the scan wraps to digit 0, so a
//  frame never mixes two snapshots. Each digit slot lasts SCAN_DIV clocks, split into 16
//  PWM phases of SCAN_DIV/16 clocks; a digit is enabled while phase < brightness.
//  Leading zeros can be blanked and a minus glyph sits left of the most significant digit.
//  Ports:
//   clock  in  system clock, posedge
//   reset  in  asynchronous, active-low
//   bus    display_mux_if.slave (snapshot inputs in, seg/dig_sel/sign_ovf/frame_tick out)
//  All outputs are registered and reflect the (digit, prescaler) state one clock earlier.
module display_mux #(
  parameter int unsigned DIGIT_NUM = 8,
  parameter int unsigned SCAN_DIV  = 1024
) (
  input  logic          clock,
  input  logic          reset,
  display_mux_if.slave  bus
);

  localparam int unsigned PH = SCAN_DIV / 16;
  localparam int unsigned SW = (PH > 1) ? $clog2(PH) : 1;
  localparam int unsigned IW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam int unsigned OW = DIGIT_NUM * 4;

  // Prescaler kept as {phase, sub}: p = phase*PH + sub, avoiding a divider for p/PH.
  logic [SW-1:0]        sub_q;
  logic [3:0]           phase_q;
  logic [IW-1:0]        idx_q;

  logic [OW-1:0]        pend_op_q;
  logic                 pend_sign_q;
  logic [3:0]           pend_bri_q;
  logic                 pend_blz_q;
  logic                 pend_q;

  logic [OW-1:0]        disp_op_q;
  logic                 disp_sign_q;
  logic [3:0]           disp_bri_q;
  logic                 disp_blz_q;

  logic [6:0]           seg_q, seg_d;
  logic [DIGIT_NUM-1:0] dig_q, dig_d;
  logic                 ovf_q, ovf_d;
  logic                 tick_q;

  logic                 sub_last;
  logic                 wrap;
  logic                 nz;
  logic [IW-1:0]        msd;
  logic [3:0]           cur_nib;
  logic                 minus_here;
  logic                 blank_here;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  assign sub_last = (sub_q == SW'(PH - 1));
  assign wrap     = sub_last && (phase_q == 4'hF) && (idx_q == IW'(DIGIT_NUM - 1));

  // Highest nonzero nibble (ascending scan, last hit wins) and the current digit's nibble.
  always_comb begin
    msd     = '0;
    cur_nib = '0;
    for (int unsigned i = 0; i < DIGIT_NUM; i++) begin
      if (disp_op_q[i*4 +: 4] != 4'h0) msd = IW'(i);
      if (idx_q == IW'(i))             cur_nib = disp_op_q[i*4 +: 4];
    end
  end

  assign nz = |disp_op_q;

  // Negative zero is suppressed by the nz term; a full-width value has no room for minus.
  assign minus_here = disp_sign_q && nz && (msd != IW'(DIGIT_NUM - 1)) &&
                      (idx_q == msd + IW'(1));
  assign blank_here = disp_blz_q && (idx_q > msd);

  always_comb begin
    if (minus_here)      seg_d = 7'h40;
    else if (blank_here) seg_d = 7'h00;
    else                 seg_d = glyph(cur_nib);
  end

  // Phase 15 can never satisfy phase < brightness, so it is always dark.
  always_comb begin
    dig_d = '0;
    for (int unsigned i = 0; i < DIGIT_NUM; i++) begin
      dig_d[i] = (idx_q == IW'(i)) && (phase_q < disp_bri_q);
    end
  end

  assign ovf_d = disp_sign_q && nz && (msd == IW'(DIGIT_NUM - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      pend_op_q   <= '0;
      pend_sign_q <= 1'b0;
      pend_bri_q  <= '0;
      pend_blz_q  <= 1'b0;
      pend_q      <= 1'b0;
      disp_op_q   <= '0;
      disp_sign_q <= 1'b0;
      disp_bri_q  <= '0;
      disp_blz_q  <= 1'b0;
      seg_q       <= '0;
      dig_q       <= '0;
      ovf_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      if (sub_last) begin
        sub_q   <= '0;
        phase_q <= phase_q + 4'd1;
        if (phase_q == 4'hF) begin
          idx_q <= (idx_q == IW'(DIGIT_NUM - 1)) ? '0 : idx_q + IW'(1);
        end
      end else begin
        sub_q <= sub_q + SW'(1);
      end

      if (wrap && pend_q) begin
        disp_op_q   <= pend_op_q;
        disp_sign_q <= pend_sign_q;
        disp_bri_q  <= pend_bri_q;
        disp_blz_q  <= pend_blz_q;
      end

      // A load on the wrap cycle refills pending after the old contents were applied,
      // so it takes effect one frame later.
      if (bus.load) begin
        pend_op_q   <= bus.operand;
        pend_sign_q <= bus.sign;
        pend_bri_q  <= bus.brightness;
        pend_blz_q  <= bus.blank_lz;
        pend_q      <= 1'b1;
      end else if (wrap) begin
        pend_q <= 1'b0;
      end

      seg_q  <= seg_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      tick_q <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.sign_ovf   = ovf_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux.sv
module tb_display_mux;
  localparam int N  = 8;
  localparam int SD = 32;
  localparam int FR = N * SD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_mux_if #(.DIGIT_NUM(N)) bus ();

  display_mux #(.DIGIT_NUM(N), .SCAN_DIV(SD)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  logic [6:0] seg_cap [N];
  int on_sum, bad_en, seg_unstable, ovf_hi, tick_cnt, tick_last, first_en, en_seen;
  int w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_load(input logic [31:0] op, input logic s, input logic [3:0] b,
                         input logic blz);
    bus.operand    = op;
    bus.sign       = s;
    bus.brightness = b;
    bus.blank_lz   = blz;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  // Waits (bounded) until frame_tick is seen at a negedge.
  task automatic sync_frame(output int waited);
    waited  = 0;
    en_seen = 0;
    while (bus.frame_tick !== 1'b1 && waited < 600) begin
      @(negedge clk);
      waited++;
      if (bus.dig_sel !== '0) en_seen++;
    end
    chk("frame_tick_seen", 32'(bus.frame_tick), 32'd1);
  endtask

  // Starts at a frame_tick negedge; sample i reflects frame position i.
  // Optionally pulses load while state position is i+1.
  task automatic capture(input int load_at, input logic [31:0] lop, input logic ls,
                         input logic [3:0] lb, input logic lblz, input int bri);
    int d, ph;
    on_sum = 0; bad_en = 0; seg_unstable = 0; ovf_hi = 0;
    tick_cnt = 0; tick_last = 0; first_en = -1;
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      d  = i / SD;
      ph = (i % SD) / 2;
      if (i % SD == 0) seg_cap[d] = bus.seg;
      else if (bus.seg !== seg_cap[d]) seg_unstable++;
      if (bus.dig_sel !== '0) begin
        if (bus.dig_sel === (8'b1 << d) && ph < bri) on_sum++;
        else bad_en++;
        if (first_en < 0) begin
          for (int j = N - 1; j >= 0; j--) if (bus.dig_sel[j]) first_en = j;
        end
      end
      if (bus.sign_ovf === 1'b1) ovf_hi++;
      if (bus.frame_tick === 1'b1) begin
        tick_cnt++;
        if (i == FR - 1) tick_last = 1;
      end
      if (i == load_at) begin
        bus.operand    = lop;
        bus.sign       = ls;
        bus.brightness = lb;
        bus.blank_lz   = lblz;
        bus.load       = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [55:0] exp_seg,
                             input int exp_on, input int exp_ovf);
    for (int d = 0; d < N; d++)
      chk($sformatf("%s_seg%0d", tag, d), 32'(seg_cap[d]), 32'(exp_seg[d*7 +: 7]));
    chk({tag, "_on_clocks"}, on_sum, exp_on * N);
    chk({tag, "_stray_enable"}, bad_en, 0);
    chk({tag, "_seg_stable"}, seg_unstable, 0);
    chk({tag, "_sign_ovf"}, ovf_hi, exp_ovf ? FR : 0);
    chk({tag, "_tick_count"}, tick_cnt, 1);
    chk({tag, "_tick_at_wrap"}, tick_last, 1);
  endtask

  initial begin
    bus.operand = '0; bus.sign = 1'b0; bus.brightness = '0;
    bus.blank_lz = 1'b0; bus.load = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 0);
    chk("rst_dig_sel", 32'(bus.dig_sel), 0);
    chk("rst_sign_ovf", 32'(bus.sign_ovf), 0);
    chk("rst_frame_tick", 32'(bus.frame_tick), 0);

    // Negative 123 with blanking.
    rst_n = 1'b1;
    do_load(32'h0000_0123, 1'b1, 4'd15, 1'b1);
    sync_frame(w);
    chk("release_to_tick", w, FR - 1);
    chk("dark_before_snapshot", en_seen, 0);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("neg123", {7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h06, 7'h5B, 7'h4F}, 30, 0);
    chk("first_enabled_digit", first_en, 0);

    // Minus overrides a shown zero when blanking is off.
    do_load(32'h0000_0123, 1'b1, 4'd15, 1'b0);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("neg123_noblank", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h06, 7'h5B, 7'h4F}, 30, 0);

    // PWM brightness 4 -> 8 clocks per slot, then 0 -> dark.
    do_load(32'h0000_0123, 1'b0, 4'd4, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 4);
    check_frame("bri4", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F}, 8, 0);
    do_load(32'h0000_0123, 1'b0, 4'd0, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 0);
    check_frame("bri0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F}, 0, 0);

    // Full-width negative: no minus, sign_ovf all frame.
    do_load(32'h9876_5432, 1'b1, 4'd15, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("ovf", {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B}, 30, 1);

    // Negative zero suppressed.
    do_load(32'h0000_0000, 1'b1, 4'd15, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("negzero", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 30, 0);

    // Hex glyphs.
    do_load(32'hFEDC_BA00, 1'b0, 4'd15, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("hex", {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h3F, 7'h3F}, 30, 0);

    // Minus in the top digit (msd = DIGIT_NUM-2).
    do_load(32'h0123_4567, 1'b1, 4'd15, 1'b1);
    sync_frame(w);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("minus_top", {7'h40, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07}, 30, 0);

    // Mid-frame load: this frame unchanged, next frame shows 42.
    capture(100, 32'h0000_0042, 1'b0, 4'd15, 1'b1, 15);
    check_frame("midload_old", {7'h40, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07}, 30, 0);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("midload_new", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}, 30, 0);

    // Load on the wrap cycle: applied one frame later.
    capture(FR - 2, 32'h0000_0007, 1'b0, 4'd15, 1'b1, 15);
    check_frame("wrapload_f0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}, 30, 0);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("wrapload_f1", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}, 30, 0);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("wrapload_f2", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07}, 30, 0);

    // Reset mid-scan at digit 5.
    repeat (5 * SD + 3) @(negedge clk);
    chk("pre_reset_dig5_on", 32'(bus.dig_sel), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_seg", 32'(bus.seg), 0);
    chk("midreset_dig_sel", 32'(bus.dig_sel), 0);
    chk("midreset_sign_ovf", 32'(bus.sign_ovf), 0);
    @(posedge clk);
    #1;
    chk("midreset_edge_seg", 32'(bus.seg), 0);
    chk("midreset_edge_dig_sel", 32'(bus.dig_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h0000_0123, 1'b1, 4'd15, 1'b1);
    sync_frame(w);
    chk("rerelease_to_tick", w, FR - 1);
    chk("rerelease_dark", en_seen, 0);
    capture(-1, '0, 1'b0, '0, 1'b0, 15);
    check_frame("after_reset", {7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h06, 7'h5B, 7'h4F}, 30, 0);
    chk("after_reset_first_digit", first_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
